// File: rtl/phy_receiver.sv
// Receive side of the two-bit forwarded-clock link: oversamples the link clock and dibits,
// hunts for the sync byte, then deframes length, payload and XOR checksum.
module phy_receiver #(
   parameter logic [7:0] SYNC_WORD      = 8'hD5,
   parameter int         TIMEOUT_CYCLES = 64,
   parameter int         MAX_LEN        = 255
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_clock_in,
   input  logic [1:0] i_data_in,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_done,
   output logic       o_frame_error,
   output logic       o_busy
);

   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [8:0]  MAX_LEN_W    = 9'(MAX_LEN);

   state_t      state_reg, state_next;
   logic        clk_meta, clk_sync, clk_prev;
   logic [1:0]  data_meta, data_sync;
   logic [7:0]  shift_reg, shift_next;
   logic [1:0]  dibit_reg, dibit_next;
   logic [7:0]  count_reg, count_next;
   logic [7:0]  csum_reg, csum_next;
   logic [15:0] timeout_reg, timeout_next;
   logic [7:0]  byte_reg, byte_next;
   logic        valid_next, done_next, error_next;
   logic        link_edge;
   logic [7:0]  shifted;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         clk_meta      <= 1'b0;
         clk_sync      <= 1'b0;
         clk_prev      <= 1'b0;
         data_meta     <= 2'b00;
         data_sync     <= 2'b00;
         state_reg     <= HUNT;
         shift_reg     <= 8'h00;
         dibit_reg     <= 2'd0;
         count_reg     <= 8'h00;
         csum_reg      <= 8'h00;
         timeout_reg   <= 16'h0000;
         byte_reg      <= 8'h00;
         o_byte_valid  <= 1'b0;
         o_frame_done  <= 1'b0;
         o_frame_error <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         clk_meta      <= i_clock_in;
         clk_sync      <= clk_meta;
         clk_prev      <= clk_sync;
         data_meta     <= i_data_in;
         data_sync     <= data_meta;
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         dibit_reg     <= dibit_next;
         count_reg     <= count_next;
         csum_reg      <= csum_next;
         timeout_reg   <= timeout_next;
         byte_reg      <= byte_next;
         o_byte_valid  <= valid_next;
         o_frame_done  <= done_next;
         o_frame_error <= error_next;
         o_busy        <= (state_next != HUNT);
      end
   end

   assign o_byte    = byte_reg;
   assign link_edge = clk_sync & ~clk_prev;
   assign shifted   = {shift_reg[5:0], data_sync};

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      dibit_next   = dibit_reg;
      count_next   = count_reg;
      csum_next    = csum_reg;
      timeout_next = (state_reg == HUNT) ? 16'h0000 : timeout_reg + 16'h0001;
      byte_next    = byte_reg;
      valid_next   = 1'b0;
      done_next    = 1'b0;
      error_next   = 1'b0;

      if (link_edge) begin
         // An edge always wins over a simultaneous timeout.
         timeout_next = 16'h0000;
         shift_next   = shifted;
         case (state_reg)
            HUNT: begin
               if (shifted == SYNC_WORD) begin
                  state_next = LEN;
                  dibit_next = 2'd0;
                  csum_next  = 8'h00;
               end
            end
            LEN: begin
               dibit_next = dibit_reg + 2'd1;
               if (dibit_reg == 2'd3) begin
                  csum_next = shifted;
                  if ({1'b0, shifted} > MAX_LEN_W) begin
                     error_next = 1'b1;
                     state_next = HUNT;
                  end else if (shifted == 8'h00) begin
                     state_next = CHECK;
                  end else begin
                     count_next = shifted;
                     state_next = PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               dibit_next = dibit_reg + 2'd1;
               if (dibit_reg == 2'd3) begin
                  byte_next  = shifted;
                  valid_next = 1'b1;
                  csum_next  = csum_reg ^ shifted;
                  count_next = count_reg - 8'h01;
                  if (count_reg == 8'h01) state_next = CHECK;
               end
            end
            default: begin
               dibit_next = dibit_reg + 2'd1;
               if (dibit_reg == 2'd3) begin
                  done_next  = (shifted == csum_reg);
                  error_next = (shifted != csum_reg);
                  state_next = HUNT;
               end
            end
         endcase
      end else if (state_reg != HUNT && timeout_reg == TIMEOUT_LAST) begin
         error_next   = 1'b1;
         state_next   = HUNT;
         shift_next   = 8'h00;
         timeout_next = 16'h0000;
      end
   end

endmodule

// File: tb/tb_phy_receiver.sv
// Directed bench for phy_receiver: frames are driven as dibit streams, expected bytes and
// frame outcomes are queued as they are sent and matched when the receiver produces them.
module tb_phy_receiver;

   logic       i_clock = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       i_clock_in = 1'b0;
   logic [1:0] i_data_in = 2'b00;
   logic [7:0] o_byte;
   logic       o_byte_valid, o_frame_done, o_frame_error, o_busy;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int valid_cycle = -1;
   int err_cycle = -1;
   int done_total = 0;
   int error_total = 0;

   logic [7:0] exp_bytes[$];
   logic [1:0] exp_events[$];   // 2'b01 = frame done, 2'b10 = frame error
   logic [7:0] frame_q[$];

   phy_receiver dut (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_clock_in   (i_clock_in),
      .i_data_in    (i_data_in),
      .o_byte       (o_byte),
      .o_byte_valid (o_byte_valid),
      .o_frame_done (o_frame_done),
      .o_frame_error(o_frame_error),
      .o_busy       (o_busy)
   );

   always #5 i_clock = ~i_clock;
   always @(posedge i_clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: sampled on the falling edge, away from register updates.
   always @(negedge i_clock) begin
      if (o_byte_valid) begin
         valid_cycle = cyc;
         check("byte_expected", {31'b0, exp_bytes.size() > 0}, 32'd1);
         if (exp_bytes.size() > 0) check("byte_value", {24'b0, o_byte}, {24'b0, exp_bytes.pop_front()});
         check("valid_alone", {30'b0, o_frame_error, o_frame_done}, 32'd0);
         $display("cycle %0d: byte 0x%02h", cyc, o_byte);
      end
      if (o_frame_done || o_frame_error) begin
         if (o_frame_done) done_total++;
         if (o_frame_error) begin
            error_total++;
            err_cycle = cyc;
         end
         check("event_expected", {31'b0, exp_events.size() > 0}, 32'd1);
         if (exp_events.size() > 0)
            check("event_kind", {30'b0, o_frame_error, o_frame_done}, {30'b0, exp_events.pop_front()});
         check("busy_at_end", {31'b0, o_busy}, 32'd0);
         $display("cycle %0d: frame %s", cyc, o_frame_done ? "done" : "error");
      end
   end

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic send_dibit(input logic [1:0] d);
      tick();
      i_data_in = d;
      repeat (9) tick();
      i_clock_in = 1'b1;
      repeat (10) tick();
      i_clock_in = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_dibit(b[7:6]);
      send_dibit(b[5:4]);
      send_dibit(b[3:2]);
      send_dibit(b[1:0]);
   endtask

   // frame_q holds sync, length, payload and checksum; the expected outcome is derived here.
   task automatic send_frame();
      logic [7:0] csum;
      int len;
      len  = int'(frame_q[1]);
      csum = frame_q[1];
      for (int i = 0; i < len; i++) begin
         exp_bytes.push_back(frame_q[2 + i]);
         csum ^= frame_q[2 + i];
      end
      exp_events.push_back(csum == frame_q[2 + len] ? 2'b01 : 2'b10);
      foreach (frame_q[i]) send_byte(frame_q[i]);
      frame_q.delete();
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check("reset_outputs", {20'b0, o_byte, o_byte_valid, o_frame_done, o_frame_error, o_busy}, 32'd0);
      i_reset_n = 1'b1;
      repeat (3) tick();
      check("idle_busy", {31'b0, o_busy}, 32'd0);

      // Good frame
      frame_q = '{8'hD5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_frame();
      // Bad checksum
      frame_q = '{8'hD5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
      send_frame();
      // Garbage dibits, then a zero-length frame
      send_dibit(2'd1); send_dibit(2'd2); send_dibit(2'd3); send_dibit(2'd0); send_dibit(2'd1);
      frame_q = '{8'hD5, 8'h00, 8'h00};
      send_frame();

      // Timeout after one payload byte of a two-byte frame
      exp_bytes.push_back(8'hAA);
      exp_events.push_back(2'b10);
      err_cycle = -1;
      send_byte(8'hD5); send_byte(8'h02); send_byte(8'hAA);
      for (int i = 0; i < 200 && err_cycle < 0; i++) tick();
      check("timeout_cycle", 32'(err_cycle - valid_cycle), 32'd64);
      check("timeout_busy", {31'b0, o_busy}, 32'd0);
      frame_q = '{8'hD5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_frame();

      // Reset in the middle of the payload
      exp_bytes.push_back(8'h11);
      send_byte(8'hD5); send_byte(8'h03); send_byte(8'h11);
      send_dibit(2'd0); send_dibit(2'd2);
      check("busy_in_payload", {31'b0, o_busy}, 32'd1);
      i_reset_n = 1'b0;
      #1;
      check("midframe_reset", {20'b0, o_byte, o_byte_valid, o_frame_done, o_frame_error, o_busy}, 32'd0);
      i_data_in  = 2'b00;
      i_clock_in = 1'b0;
      repeat (4) tick();
      i_reset_n = 1'b1;
      repeat (4) tick();
      frame_q = '{8'hD5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_frame();

      // Back-to-back frames
      frame_q = '{8'hD5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_frame();
      frame_q = '{8'hD5, 8'h02, 8'h5A, 8'hA5, 8'hFD};
      send_frame();

      repeat (30) tick();
      check("bytes_left", 32'(exp_bytes.size()), 32'd0);
      check("events_left", 32'(exp_events.size()), 32'd0);
      check("done_total", 32'(done_total), 32'd6);
      check("error_total", 32'(error_total), 32'd2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
